// File: rtl/button_debounce.sv
// Synchronises and debounces a bouncing push-button into one pulse per press, with optional auto-repeat.
// Latency SYNC_STAGES+DEBOUNCE_CYCLES cycles from first sampled edge to pulse/level; no backpressure, free-running.
module button_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int CNT_WIDTH       = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_in,
    output logic       button_pulse,
    output logic       button_level,
    output logic [7:0] press_cnt
);

    localparam logic [CNT_WIDTH-1:0] DEB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DLY_LAST = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] PER_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic                   rep_armed, rep_armed_nxt;
    logic                   press_fire, rep_fire;
    logic                   press_q, pulse_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_in;

    assign s_in = sync_q[SYNC_STAGES-1];

    // Outputs are re-registered once more so pulse and level share the same total latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            state        <= IDLE;
            cnt          <= '0;
            rep_armed    <= 1'b0;
            press_q      <= 1'b0;
            pulse_q      <= 1'b0;
            button_pulse <= 1'b0;
            button_level <= 1'b0;
            press_cnt    <= 8'd0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], button_in};
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rep_armed    <= rep_armed_nxt;
            press_q      <= press_fire;
            pulse_q      <= press_fire | rep_fire;
            button_pulse <= pulse_q;
            button_level <= (state == HELD) || (state == RELEASE_WAIT);
            if (press_q) begin
                press_cnt <= press_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rep_armed_nxt = rep_armed;
        press_fire    = 1'b0;
        rep_fire      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt       = '0;
                rep_armed_nxt = 1'b0;
                if (s_in) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s_in) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt     = HELD;
                    cnt_nxt       = '0;
                    rep_armed_nxt = 1'b0;
                    press_fire    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!s_in) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end else if (REPEAT_EN != 0) begin
                    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
                    if (cnt == (rep_armed ? PER_LAST : DLY_LAST)) begin
                        rep_fire      = 1'b1;
                        cnt_nxt       = '0;
                        rep_armed_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s_in) begin
                    state_nxt     = HELD;
                    cnt_nxt       = '0;
                    rep_armed_nxt = 1'b0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: one instance without and one with auto-repeat, same stimulus.
module tb_button_debounce;

    logic       clk;
    logic       rst;
    logic       button_in;
    logic       pulse0, level0, pulse1, level1;
    logic [7:0] cnt0, cnt1;

    int vecs, errs, cyc, pulses0, pulses1, dbl;
    logic prev0, prev1;
    int p1_times[$];

    button_debounce #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .REPEAT_EN(0),
        .REPEAT_DELAY(64), .REPEAT_PERIOD(32), .CNT_WIDTH(8)
    ) dut0 (
        .clk(clk), .rst(rst), .button_in(button_in),
        .button_pulse(pulse0), .button_level(level0), .press_cnt(cnt0)
    );

    button_debounce #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16), .REPEAT_EN(1),
        .REPEAT_DELAY(64), .REPEAT_PERIOD(32), .CNT_WIDTH(8)
    ) dut1 (
        .clk(clk), .rst(rst), .button_in(button_in),
        .button_pulse(pulse1), .button_level(level1), .press_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // After tick(), cyc is the index of the posedge just taken; inputs set now are sampled at cyc+1.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (pulse0) begin
            pulses0++;
            if (prev0) dbl++;
        end
        if (pulse1) begin
            pulses1++;
            p1_times.push_back(cyc);
            if (prev1) dbl++;
        end
        prev0 = pulse0;
        prev1 = pulse1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        button_in = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        button_in = 1'b0;
        repeat (3) tick();
        vecs++; if (pulse0 !== 1'b0) begin errs++; $display("FAIL reset_pulse0 got %b want 0", pulse0); end
        vecs++; if (level0 !== 1'b0) begin errs++; $display("FAIL reset_level0 got %b want 0", level0); end
        vecs++; if (cnt0 !== 8'd0) begin errs++; $display("FAIL reset_cnt0 got %0d want 0", cnt0); end
        vecs++; if ({pulse1, level1, cnt1} !== 10'd0) begin errs++; $display("FAIL reset_dut1 got %b/%b/%0d want 0/0/0", pulse1, level1, cnt1); end
        rst = 1'b0;
        repeat (5) tick();
        vecs++; if (level0 !== 1'b0 || pulses0 != 0) begin errs++; $display("FAIL idle_after_reset level %b pulses %0d want 0/0", level0, pulses0); end
    endtask

    task automatic test_clean_press();
        int base;
        do_reset();
        base = pulses0;
        button_in = 1'b1;
        repeat (18) tick();
        vecs++; if (pulse0 !== 1'b0 || level0 !== 1'b0) begin errs++; $display("FAIL clean_early got pulse %b level %b want 0/0", pulse0, level0); end
        tick();
        vecs++; if (pulse0 !== 1'b1) begin errs++; $display("FAIL clean_pulse got %b want 1", pulse0); end
        vecs++; if (level0 !== 1'b1) begin errs++; $display("FAIL clean_level_rise got %b want 1", level0); end
        vecs++; if (cnt0 !== 8'd1) begin errs++; $display("FAIL clean_press_cnt got %0d want 1", cnt0); end
        tick();
        vecs++; if (pulse0 !== 1'b0) begin errs++; $display("FAIL clean_pulse_width got %b want 0", pulse0); end
        repeat (180) tick();
        vecs++; if (pulses0 - base != 1) begin errs++; $display("FAIL clean_single_pulse got %0d want 1", pulses0 - base); end
        button_in = 1'b0;
        repeat (18) tick();
        vecs++; if (level0 !== 1'b1) begin errs++; $display("FAIL clean_level_hold got %b want 1", level0); end
        tick();
        vecs++; if (level0 !== 1'b0) begin errs++; $display("FAIL clean_level_fall got %b want 0", level0); end
    endtask

    task automatic test_bounce();
        int base;
        do_reset();
        base = pulses0;
        for (int i = 0; i < 40; i++) begin
            button_in = ((i / 3) % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        vecs++; if (pulses0 - base != 0 || level0 !== 1'b0) begin errs++; $display("FAIL bounce_quiet got pulses %0d level %b want 0/0", pulses0 - base, level0); end
        button_in = 1'b1;
        repeat (18) tick();
        vecs++; if (pulses0 - base != 0) begin errs++; $display("FAIL bounce_early got %0d pulses want 0", pulses0 - base); end
        tick();
        vecs++; if (pulse0 !== 1'b1) begin errs++; $display("FAIL bounce_pulse got %b want 1", pulse0); end
        repeat (30) tick();
        vecs++; if (pulses0 - base != 1 || cnt0 !== 8'd1) begin errs++; $display("FAIL bounce_total got pulses %0d cnt %0d want 1/1", pulses0 - base, cnt0); end
        button_in = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_terminal_glitch();
        int base0, base1;
        do_reset();
        base0 = pulses0;
        base1 = pulses1;
        for (int i = 1; i <= 17; i++) begin
            button_in = (i == 16) ? 1'b0 : 1'b1;
            tick();
        end
        button_in = 1'b0;
        repeat (40) tick();
        vecs++; if (pulses0 - base0 != 0 || pulses1 - base1 != 0) begin errs++; $display("FAIL glitch_pulse got %0d/%0d pulses want 0/0", pulses0 - base0, pulses1 - base1); end
        vecs++; if (level0 !== 1'b0 || cnt0 !== 8'd0) begin errs++; $display("FAIL glitch_level got level %b cnt %0d want 0/0", level0, cnt0); end
    endtask

    task automatic test_release_glitch();
        int base;
        do_reset();
        button_in = 1'b1;
        repeat (40) tick();
        base = pulses0;
        button_in = 1'b0;
        repeat (10) tick();
        button_in = 1'b1;
        repeat (30) tick();
        vecs++; if (level0 !== 1'b1 || pulses0 - base != 0) begin errs++; $display("FAIL release_bounce got level %b pulses %0d want 1/0", level0, pulses0 - base); end
        button_in = 1'b0;
        repeat (25) tick();
        vecs++; if (level0 !== 1'b0 || cnt0 !== 8'd1) begin errs++; $display("FAIL release_final got level %b cnt %0d want 0/1", level0, cnt0); end
    endtask

    task automatic test_repeat();
        int t, base0;
        int exp_t[5];
        do_reset();
        p1_times.delete();
        base0 = pulses0;
        t = cyc + 19;
        exp_t[0] = t;       exp_t[1] = t + 64;  exp_t[2] = t + 96;
        exp_t[3] = t + 128; exp_t[4] = t + 160;
        button_in = 1'b1;
        repeat (200) tick();
        vecs++; if (p1_times.size() != 5) begin errs++; $display("FAIL repeat_count got %0d want 5", p1_times.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < p1_times.size()) begin
                vecs++;
                if (p1_times[i] != exp_t[i]) begin errs++; $display("FAIL repeat_time[%0d] got %0d want %0d", i, p1_times[i], exp_t[i]); end
            end
        end
        vecs++; if (cnt1 !== 8'd1) begin errs++; $display("FAIL repeat_press_cnt got %0d want 1", cnt1); end
        vecs++; if (pulses0 - base0 != 1) begin errs++; $display("FAIL norepeat_pulses got %0d want 1", pulses0 - base0); end
        button_in = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_reset_mid_hold();
        int base;
        do_reset();
        button_in = 1'b1;
        repeat (19 + 29) tick();
        rst = 1'b1;
        tick();
        vecs++; if ({pulse0, level0, cnt0} !== 10'd0) begin errs++; $display("FAIL midrst_dut0 got %b/%b/%0d want 0/0/0", pulse0, level0, cnt0); end
        vecs++; if ({pulse1, level1, cnt1} !== 10'd0) begin errs++; $display("FAIL midrst_dut1 got %b/%b/%0d want 0/0/0", pulse1, level1, cnt1); end
        rst = 1'b0;
        base = pulses0;
        repeat (18) tick();
        vecs++; if (pulses0 - base != 0 || level0 !== 1'b0) begin errs++; $display("FAIL midrst_early got pulses %0d level %b want 0/0", pulses0 - base, level0); end
        tick();
        vecs++; if (pulse0 !== 1'b1 || cnt0 !== 8'd1) begin errs++; $display("FAIL midrst_repulse got pulse %b cnt %0d want 1/1", pulse0, cnt0); end
        button_in = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_wrap();
        int base;
        do_reset();
        base = pulses0;
        for (int i = 0; i < 256; i++) begin
            button_in = 1'b1;
            repeat (20) tick();
            button_in = 1'b0;
            repeat (20) tick();
            if (i == 254) begin
                vecs++;
                if (cnt0 !== 8'd255) begin errs++; $display("FAIL wrap_255 got %0d want 255", cnt0); end
            end
        end
        vecs++; if (cnt0 !== 8'd0) begin errs++; $display("FAIL wrap_cnt got %0d want 0", cnt0); end
        vecs++; if (pulses0 - base != 256) begin errs++; $display("FAIL wrap_pulses got %0d want 256", pulses0 - base); end
    endtask

    initial begin
        vecs = 0; errs = 0; cyc = 0; pulses0 = 0; pulses1 = 0; dbl = 0;
        prev0 = 1'b0; prev1 = 1'b0;
        rst = 1'b1;
        button_in = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_terminal_glitch();
        test_release_glitch();
        test_repeat();
        test_reset_mid_hold();
        test_wrap();
        vecs++; if (dbl != 0) begin errs++; $display("FAIL back_to_back_pulses got %0d want 0", dbl); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditioning stage directly upstream of led_display_ctrl; its button_pulse output drives led_display_ctrl.button.
- Takes the raw, asynchronous, bouncing board push-button, synchronises and debounces it, and emits exactly one single-cycle pulse per accepted press.
- Optional auto-repeat while held; also exports the debounced level.

Parameters:
- SYNC_STAGES, 2: flip-flop synchroniser depth (min 2).
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles to accept a level change (10 ms at 100 MHz; min 2).
- REPEAT_EN, 0: 1 enables auto-repeat pulses while held.
- REPEAT_DELAY, 50000000: held cycles after the press pulse before the first repeat pulse.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses.
- CNT_WIDTH, 26: counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- button_in  input  1  raw push-button, asynchronous, active-high, bouncing
- button_pulse  output  1  one-cycle pulse per accepted press (and per repeat)
- button_level  output  1  debounced button level
- press_cnt  output  8  accepted presses since reset, repeats excluded, wraps 255->0

Behaviour:
- Clocking and reset
  - One clock domain, clk posedge only.
  - Reset is synchronous and active-high on rst.
  - Reset values: synchroniser 0, FSM IDLE, counter 0, button_pulse 0, button_level 0, press_cnt 0.
- Synchroniser
  - button_in passes through a SYNC_STAGES-deep FF chain.
  - The last stage is s_in; only s_in feeds the FSM.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: counter=0. If s_in=1, go to PRESS_WAIT with counter=1.
  - PRESS_WAIT:
    - s_in=0: return to IDLE, counter=0, no pulse.
    - s_in=1 and counter==DEBOUNCE_CYCLES-1: go to HELD, counter=0; button_pulse=1 on the next cycle only; button_level=1; press_cnt+1.
    - Otherwise counter+1.
  - HELD:
    - s_in=1: counter runs only when REPEAT_EN=1.
      - First repeat fires when counter==REPEAT_DELAY-1: one-cycle button_pulse, counter=0.
      - Later repeats fire every REPEAT_PERIOD cycles.
      - press_cnt is unchanged by repeats.
    - s_in=0: go to RELEASE_WAIT, counter=1.
  - RELEASE_WAIT:
    - s_in=1: return to HELD, counter=0. The repeat schedule restarts from REPEAT_DELAY and no pulse is issued.
    - s_in=0 and counter==DEBOUNCE_CYCLES-1: go to IDLE, button_level=0.
    - Otherwise counter+1.
- Latency
  - Raw rising edge held clean, first sampled high at posedge k: button_pulse is high during the cycle after posedge k+SYNC_STAGES+DEBOUNCE_CYCLES.
  - The same total applies to button_level rising, and to button_level falling after a clean release.
- Outputs
  - All outputs are registered; no combinational path from button_in.
  - button_pulse is never high two consecutive cycles.
- Boundary conditions
  - A glitch on the terminal-count cycle aborts the transition, with no pulse and no level change.
  - A bounce shorter than DEBOUNCE_CYCLES in either direction produces no pulse.
  - press_cnt wraps 255->0.
  - rst asserted mid-count or mid-held returns to IDLE and clears everything the next cycle. A button still held at reset release must debounce afresh, so it produces one pulse after the full latency.
- REPEAT_EN=0: HELD holds the counter at 0; there is exactly one pulse per press however long the button is held.

Test Plan (sim params: SYNC_STAGES=2, DEBOUNCE_CYCLES=16, REPEAT_DELAY=64, REPEAT_PERIOD=32, CNT_WIDTH=8):
- Clean press: button_in 0->1 sampled at posedge 10, held 200 cycles, REPEAT_EN=0 -> single pulse in the cycle after posedge 28; button_level=1 from then; press_cnt=1; button_level falls 18 cycles after release.
- Bounce: toggle button_in every 3 cycles for 40 cycles, then hold 1 -> exactly one pulse, 18 cycles after the last 0->1 edge; no pulse during the bouncing; press_cnt=1.
- Terminal glitch: hold 1 for 17 sampled cycles with a 1-cycle 0 on sampled cycle 16, then return to 0 -> no pulse, button_level stays 0.
- Auto-repeat (REPEAT_EN=1): hold 200 cycles -> pulses at T, T+64, T+96, T+128, T+160 (T = press pulse cycle) while still held; press_cnt=1.
- Reset mid-hold: assert rst for 1 cycle at T+30 while held -> all outputs 0 next cycle; a second pulse 18 cycles after rst deasserts; press_cnt=1.
- Wrap: 256 clean presses -> press_cnt=0 and exactly 256 pulses counted.
